// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port among three pixel
// requesters, with a built-in full-screen clear sweep.
module vga_plot_arbiter #(
    parameter int SCR_W       = 160,
    parameter int SCR_H       = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOR_BITS  = 3,
    parameter int CLEAR_COLOR = 0
) (
    input  logic                    Clck,
    input  logic                    Reset,
    input  logic                    clear_req,
    output logic                    clear_busy,
    input  logic [2:0]              req_valid,
    output logic [2:0]              req_ready,
    input  logic [3*X_BITS-1:0]     req_x,
    input  logic [3*Y_BITS-1:0]     req_y,
    input  logic [3*COLOR_BITS-1:0] req_color,
    output logic [X_BITS-1:0]       plot_x,
    output logic [Y_BITS-1:0]       plot_y,
    output logic [COLOR_BITS-1:0]   plot_color,
    output logic                    plot_en,
    output logic [1:0]              grant_id,
    output logic                    oob_flag
);

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    localparam logic [X_BITS-1:0] X_LIM = X_BITS'(SCR_W);
    localparam logic [Y_BITS-1:0] Y_LIM = Y_BITS'(SCR_H);
    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(SCR_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(SCR_H - 1);
    localparam logic [COLOR_BITS-1:0] CLR_C = COLOR_BITS'(CLEAR_COLOR);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_last;
    logic [X_BITS-1:0]       r_cx;
    logic [Y_BITS-1:0]       r_cy;
    logic [X_BITS-1:0]       r_px;
    logic [Y_BITS-1:0]       r_py;
    logic [COLOR_BITS-1:0]   r_pc;
    logic                    r_pen;
    logic [1:0]              r_gid;
    logic                    r_oob;
    logic                    r_busy;

    logic [1:0]              w_c0;
    logic [1:0]              w_c1;
    logic [1:0]              w_c2;
    logic [2:0]              w_grant;
    logic [1:0]              w_gid;
    logic                    w_xfer;
    logic                    w_oob;
    logic                    w_last_px;
    logic [X_BITS-1:0]       w_sel_x;
    logic [Y_BITS-1:0]       w_sel_y;
    logic [COLOR_BITS-1:0]   w_sel_c;

    // Search order: last+1, last+2, last+3 (mod 3)
    assign w_c0 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    assign w_c1 = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
    assign w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;

    assign w_last_px = (r_cx == X_MAX) && (r_cy == Y_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 3'b000;
        w_gid       = 2'd0;
        unique case (r_state)
            S_RUN: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                end else if (req_valid[w_c0]) begin
                    w_gid          = w_c0;
                    w_grant[w_c0]  = 1'b1;
                end else if (req_valid[w_c1]) begin
                    w_gid          = w_c1;
                    w_grant[w_c1]  = 1'b1;
                end else if (req_valid[w_c2]) begin
                    w_gid          = w_c2;
                    w_grant[w_c2]  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_last_px) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign w_xfer    = |w_grant;
    assign req_ready = Reset ? 3'b000 : w_grant;

    assign w_sel_x = req_x[w_gid*X_BITS +: X_BITS];
    assign w_sel_y = req_y[w_gid*Y_BITS +: Y_BITS];
    assign w_sel_c = req_color[w_gid*COLOR_BITS +: COLOR_BITS];
    assign w_oob   = (w_sel_x >= X_LIM) || (w_sel_y >= Y_LIM);

    always_ff @(posedge Clck) begin
        if (Reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            r_last <= 2'd2;
            r_cx   <= '0;
            r_cy   <= '0;
            r_px   <= '0;
            r_py   <= '0;
            r_pc   <= '0;
            r_pen  <= 1'b0;
            r_gid  <= 2'd0;
            r_oob  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_pen  <= 1'b0;
            r_busy <= 1'b0;
            if (r_state == S_CLEAR) begin
                r_px   <= r_cx;
                r_py   <= r_cy;
                r_pc   <= CLR_C;
                r_pen  <= 1'b1;
                r_gid  <= 2'd3;
                r_busy <= 1'b1;
                if (r_cx == X_MAX) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == Y_MAX) ? '0 : r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end else if (w_xfer) begin
                r_last <= w_gid;
                // Off-screen pixels are consumed but never strobed
                if (w_oob) begin
                    r_oob <= 1'b1;
                end else begin
                    r_px  <= w_sel_x;
                    r_py  <= w_sel_y;
                    r_pc  <= w_sel_c;
                    r_pen <= 1'b1;
                    r_gid <= w_gid;
                end
            end
        end
    end

    assign plot_x     = r_px;
    assign plot_y     = r_py;
    assign plot_color = r_pc;
    assign plot_en    = r_pen;
    assign grant_id   = r_gid;
    assign oob_flag   = r_oob;
    assign clear_busy = r_busy;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: directed vectors push expected
// strobes, a negedge monitor pops and compares every plot_en.
module tb_vga_plot_arbiter;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [1:0] g;
    } exp_t;

    logic        Clck = 1'b0;
    logic        Reset = 1'b1;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic [2:0]  req_valid = 3'b000;
    logic [2:0]  req_ready;
    logic [23:0] req_x = '0;
    logic [20:0] req_y = '0;
    logic [8:0]  req_color = '0;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_color;
    logic        plot_en;
    logic [1:0]  grant_id;
    logic        oob_flag;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    vga_plot_arbiter dut (
        .Clck(Clck), .Reset(Reset), .clear_req(clear_req),
        .clear_busy(clear_busy), .req_valid(req_valid),
        .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .req_color(req_color), .plot_x(plot_x), .plot_y(plot_y),
        .plot_color(plot_color), .plot_en(plot_en),
        .grant_id(grant_id), .oob_flag(oob_flag)
    );

    always #5 Clck = ~Clck;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic set_req(input int i, input int x, input int y,
                           input int c);
        req_x[i*8 +: 8]     = 8'(x);
        req_y[i*7 +: 7]     = 7'(y);
        req_color[i*3 +: 3] = 3'(c);
    endtask

    task automatic push(input int x, input int y, input int c,
                        input int g);
        exp_t e;
        e.x = 8'(x);
        e.y = 7'(y);
        e.c = 3'(c);
        e.g = 2'(g);
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge Clck);
        #1;
    endtask

    task automatic cyc_ready(input logic [2:0] er, input string nm);
        @(negedge Clck);
        chk(nm, {29'd0, req_ready}, {29'd0, er});
        tick();
    endtask

    always @(negedge Clck) begin
        if (plot_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_plot", {31'd0, plot_en}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("plot", {12'd0, plot_x, plot_y, plot_color, grant_id},
                    {12'd0, e});
                chk("busy", {31'd0, clear_busy}, {31'd0, (e.g == 2'd3)});
            end
        end
    end

    initial begin
        bit done;
        set_req(0, 10, 20, 1);
        set_req(1, 30, 40, 2);
        set_req(2, 50, 60, 3);
        req_valid = 3'b111;
        repeat (2) tick();
        @(negedge Clck);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_out", {17'd0, plot_x, plot_y, plot_color, plot_en, grant_id},
            32'd0);
        chk("rst_flags", {30'd0, oob_flag, clear_busy}, 32'd0);
        @(posedge Clck);
        #1;
        Reset = 1'b0;
        req_valid = 3'b000;
        tick();

        // round robin with all valid
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 3;
            push(10 + 20*g, 20 + 20*g, g + 1, g);
            cyc_ready(3'(1 << g), "rr_ready");
        end
        req_valid = 3'b000;
        tick();

        // single requester
        set_req(1, 5, 7, 5);
        req_valid = 3'b010;
        push(5, 7, 5, 1);
        cyc_ready(3'b010, "single_ready");
        req_valid = 3'b000;
        tick();

        // out-of-range x, then y, then in-range corner
        set_req(0, 160, 0, 2);
        req_valid = 3'b001;
        cyc_ready(3'b001, "oobx_ready");
        req_valid = 3'b000;
        @(negedge Clck);
        chk("oob_set", {31'd0, oob_flag}, 32'd1);
        tick();
        set_req(2, 0, 120, 1);
        req_valid = 3'b100;
        cyc_ready(3'b100, "ooby_ready");
        set_req(1, 159, 119, 6);
        req_valid = 3'b010;
        push(159, 119, 6, 1);
        cyc_ready(3'b010, "corner_ready");
        req_valid = 3'b000;
        repeat (3) tick();
        @(negedge Clck);
        chk("oob_sticky", {31'd0, oob_flag}, 32'd1);
        tick();

        // clear beats same-cycle valid
        clear_req = 1'b1;
        req_valid = 3'b001;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                push(xx, yy, 0, 3);
        cyc_ready(3'b000, "clear_wins");
        clear_req = 1'b0;
        req_valid = 3'b000;
        repeat (50) tick();
        req_valid = 3'b111;
        clear_req = 1'b1;
        cyc_ready(3'b000, "clear_no_ready");
        req_valid = 3'b000;
        clear_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge Clck);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk("clear_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(posedge Clck);
        #1;
        @(negedge Clck);
        chk("clear_done", {30'd0, clear_busy, plot_en}, 32'd0);
        chk("oob_after_clear", {31'd0, oob_flag}, 32'd1);
        tick();

        // pointer untouched by clear: last was 1
        set_req(0, 10, 20, 1);
        set_req(2, 50, 60, 3);
        req_valid = 3'b111;
        push(50, 60, 3, 2);
        cyc_ready(3'b100, "ptr_after_clear");
        req_valid = 3'b000;
        tick();

        // reset during clear, then restart from origin
        clear_req = 1'b1;
        push(0, 0, 0, 3);
        push(1, 0, 0, 3);
        push(2, 0, 0, 3);
        tick();
        clear_req = 1'b0;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clck);
        chk("abort_out", {29'd0, plot_en, clear_busy, oob_flag}, 32'd0);
        tick();
        clear_req = 1'b1;
        push(0, 0, 0, 3);
        push(1, 0, 0, 3);
        tick();
        clear_req = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clck);
        chk("abort2_out", {30'd0, plot_en, clear_busy}, 32'd0);
        tick();

        // pointer after reset is 2
        req_valid = 3'b100;
        push(50, 60, 3, 2);
        cyc_ready(3'b100, "rst_ptr_r2");
        req_valid = 3'b101;
        push(10, 20, 1, 0);
        cyc_ready(3'b001, "rst_ptr_r0");
        req_valid = 3'b000;
        repeat (3) tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
